// File: rtl/int_res_mem_arb_if.sv
// Requester and memory-side bundle of the intermediate-results memory arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface int_res_mem_arb_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]             rd_req, rd_lock, rd_width, rd_gnt, rd_rvalid;
  logic [N_REQ-1:0][ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]            rd_rdata;
  logic [N_REQ-1:0]             wr_req, wr_lock, wr_width, wr_gnt;
  logic [N_REQ-1:0][ADDR_W-1:0] wr_addr;
  logic [N_REQ-1:0][DATA_W-1:0] wr_data;
  logic                         mem_rd_en, mem_rd_width;
  logic [ADDR_W-1:0]            mem_rd_addr;
  logic [DATA_W-1:0]            mem_rd_data;
  logic                         mem_wr_en, mem_wr_width;
  logic [ADDR_W-1:0]            mem_wr_addr;
  logic [DATA_W-1:0]            mem_wr_data;
  logic [15:0]                  conflict_cnt;
  logic                         oor_err;

  modport slave (
    input  rd_req, rd_lock, rd_addr, rd_width, wr_req, wr_lock, wr_addr, wr_width, wr_data,
           mem_rd_data,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt, mem_rd_en, mem_rd_addr, mem_rd_width,
           mem_wr_en, mem_wr_addr, mem_wr_width, mem_wr_data, conflict_cnt, oor_err
  );
  modport master (
    output rd_req, rd_lock, rd_addr, rd_width, wr_req, wr_lock, wr_addr, wr_width, wr_data,
           mem_rd_data,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt, mem_rd_en, mem_rd_addr, mem_rd_width,
           mem_wr_en, mem_wr_addr, mem_wr_width, mem_wr_data, conflict_cnt, oor_err
  );
endinterface

// File: rtl/int_res_mem_arb.sv
// Round-robin read/write arbiter for the banked intermediate-results memory,
// with per-port lock, read-vs-write bank conflict stall and out-of-range flag.
module int_res_mem_arb_rr #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  input  logic [IW-1:0] ptr,
  input  logic          lock_act,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    any = 1'b0;
    idx = ptr;
    if (lock_act && req[ptr] && lock[ptr]) any = 1'b1;
    else
      for (int i = 1; i <= N; i++)
        if (!any && req[(int'(ptr) + i) % N]) begin
          any = 1'b1;
          idx = IW'((int'(ptr) + i) % N);
        end
  end
endmodule

module int_res_mem_arb #(
  parameter int N_REQ      = 3,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BANK_DEPTH = 4096
) (
  input logic                clk,
  input logic                rst_n,
  int_res_mem_arb_if.slave   bus
);
  localparam int          IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LIMIT = 4 * BANK_DEPTH;

  // Out-of-range addresses land in bank 0, so they conflict as bank 0 accesses.
  function automatic logic [3:0] bank_mask(input logic [ADDR_W-1:0] a, input logic w);
    int unsigned b;
    b = (32'(a) >= LIMIT) ? 0 : 32'(a) / BANK_DEPTH;
    if (w) return b[0] ? 4'b1010 : 4'b0101;
    return 4'b0001 << b[1:0];
  endfunction

  logic [IW-1:0]    rd_ptr, wr_ptr, rd_idx, wr_idx;
  logic             rd_lact, wr_lact, rd_any, wr_any, rd_ok, wr_ok, conflict;
  logic [N_REQ-1:0] rd_rvalid;
  logic [15:0]      conflict_cnt;
  logic             oor_err;
  logic [ADDR_W-1:0] rd_a, wr_a;
  logic             rd_w, wr_w;

  int_res_mem_arb_rr #(.N(N_REQ), .IW(IW)) u_rd (
    .req(bus.rd_req), .lock(bus.rd_lock), .ptr(rd_ptr), .lock_act(rd_lact),
    .any(rd_any), .idx(rd_idx));
  int_res_mem_arb_rr #(.N(N_REQ), .IW(IW)) u_wr (
    .req(bus.wr_req), .lock(bus.wr_lock), .ptr(wr_ptr), .lock_act(wr_lact),
    .any(wr_any), .idx(wr_idx));

  assign rd_a = bus.rd_addr[rd_idx];
  assign rd_w = bus.rd_width[rd_idx];
  assign wr_a = bus.wr_addr[wr_idx];
  assign wr_w = bus.wr_width[wr_idx];

  // Write always wins a bank clash; the read is simply not granted this cycle.
  assign conflict = rd_any && wr_any && (|(bank_mask(rd_a, rd_w) & bank_mask(wr_a, wr_w)));
  assign rd_ok    = rst_n && rd_any && !conflict;
  assign wr_ok    = rst_n && wr_any;

  assign bus.rd_gnt       = rd_ok ? (N_REQ'(1) << rd_idx) : '0;
  assign bus.wr_gnt       = wr_ok ? (N_REQ'(1) << wr_idx) : '0;
  assign bus.mem_rd_en    = rd_ok;
  assign bus.mem_rd_addr  = rd_ok ? rd_a : '0;
  assign bus.mem_rd_width = rd_ok && rd_w;
  assign bus.mem_wr_en    = wr_ok;
  assign bus.mem_wr_addr  = wr_ok ? wr_a : '0;
  assign bus.mem_wr_width = wr_ok && wr_w;
  assign bus.mem_wr_data  = wr_ok ? bus.wr_data[wr_idx] : {DATA_W{1'b0}};
  assign bus.rd_rvalid    = rd_rvalid;
  assign bus.rd_rdata     = (|rd_rvalid) ? bus.mem_rd_data : '0;
  assign bus.conflict_cnt = conflict_cnt;
  assign bus.oor_err      = oor_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= IW'(N_REQ - 1);
      wr_ptr       <= IW'(N_REQ - 1);
      rd_lact      <= 1'b0;
      wr_lact      <= 1'b0;
      rd_rvalid    <= '0;
      conflict_cnt <= '0;
      oor_err      <= 1'b0;
    end else begin
      rd_rvalid <= bus.rd_gnt;
      if (rd_ok) begin
        rd_ptr  <= rd_idx;
        rd_lact <= bus.rd_lock[rd_idx];
      end else if (!bus.rd_req[rd_ptr]) rd_lact <= 1'b0;
      if (wr_ok) begin
        wr_ptr  <= wr_idx;
        wr_lact <= bus.wr_lock[wr_idx];
      end else if (!bus.wr_req[wr_ptr]) wr_lact <= 1'b0;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      if ((rd_ok && 32'(rd_a) >= LIMIT) || (wr_ok && 32'(wr_a) >= LIMIT)) oor_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_int_res_mem_arb.sv
// Directed bench for int_res_mem_arb: round-robin, lock, bank conflicts,
// out-of-range flag, reset mid-read and conflict counter saturation.
module tb_int_res_mem_arb;
  localparam int BD = 4096;
  logic clk, rst_n;
  int total = 0, bad = 0;

  int_res_mem_arb_if #(.N_REQ(3), .ADDR_W(16), .DATA_W(32)) bus();
  int_res_mem_arb #(.N_REQ(3), .ADDR_W(16), .DATA_W(32), .BANK_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_req = '0; bus.rd_lock = '0; bus.rd_width = '0; bus.rd_addr = '0;
    bus.wr_req = '0; bus.wr_lock = '0; bus.wr_width = '0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.mem_rd_data = '0;
  endtask

  initial begin
    logic [2:0] pg;
    idle();
    rst_n = 1'b0;
    bus.rd_req = 3'b111; bus.wr_req = 3'b111;
    #2;
    chk("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 0);
    chk("rst_mem_en", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk("rst_rvalid", 32'(bus.rd_rvalid), 0);
    chk("rst_cnt_oor", {15'd0, bus.oor_err, bus.conflict_cnt}, 0);
    idle();
    #10 rst_n = 1'b1;

    // plain round robin, reads all in bank 1
    tick();
    bus.rd_req = 3'b111;
    bus.rd_addr[0] = 16'(BD + 10); bus.rd_addr[1] = 16'(BD + 11); bus.rd_addr[2] = 16'(BD + 12);
    pg = 3'b000;
    for (int k = 0; k < 6; k++) begin
      bus.mem_rd_data = 32'hA000 + 32'(k);
      #1;
      chk($sformatf("rr_gnt%0d", k), 32'(bus.rd_gnt), 32'(3'b001 << (k % 3)));
      chk($sformatf("rr_addr%0d", k), 32'(bus.mem_rd_addr), 32'(BD + 10 + (k % 3)));
      chk($sformatf("rr_rvalid%0d", k), 32'(bus.rd_rvalid), 32'(pg));
      chk($sformatf("rr_rdata%0d", k), bus.rd_rdata, (k == 0) ? 32'd0 : 32'hA000 + 32'(k));
      pg = 3'b001 << (k % 3);
      tick();
    end
    bus.rd_req = '0; bus.mem_rd_data = 32'hBEEF;
    #1;
    chk("rr_last_rvalid", 32'(bus.rd_rvalid), 32'b100);
    chk("rr_last_rdata", bus.rd_rdata, 32'hBEEF);

    // lock: move pointer to 0, then requester 1 locks for 4 cycles
    tick();
    bus.rd_req = 3'b001;
    #1 chk("lk_pre", 32'(bus.rd_gnt), 32'b001);
    tick();
    bus.rd_req = 3'b111; bus.rd_lock = 3'b010;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("lk_gnt%0d", k), 32'(bus.rd_gnt), 32'b010);
      tick();
    end
    bus.rd_req = 3'b101; bus.rd_lock = '0;
    #1 chk("lk_release", 32'(bus.rd_gnt), 32'b100);
    tick();
    idle();

    // bank conflict: read single bank 0 vs write double bank 2 (pair 0,2)
    bus.rd_req = 3'b001; bus.rd_addr[0] = 16'd5;
    bus.wr_req = 3'b001; bus.wr_addr[0] = 16'(2 * BD + 7); bus.wr_width = 3'b001;
    #1;
    chk("cf_wr_gnt", 32'(bus.wr_gnt), 32'b001);
    chk("cf_rd_gnt", 32'(bus.rd_gnt), 0);
    chk("cf_mem_rd_en", 32'(bus.mem_rd_en), 0);
    tick();
    bus.wr_req = '0;
    #1;
    chk("cf_cnt1", 32'(bus.conflict_cnt), 1);
    chk("cf_rd_after", 32'(bus.rd_gnt), 32'b001);
    tick();
    idle();

    // no conflict: read single bank 1, write single bank 0, same cycle
    bus.rd_req = 3'b010; bus.rd_addr[1] = 16'(BD);
    bus.wr_req = 3'b010; bus.wr_addr[1] = 16'd0; bus.wr_data[1] = 32'hDEADBEEF;
    #1;
    chk("nc_rd_gnt", 32'(bus.rd_gnt), 32'b010);
    chk("nc_wr_gnt", 32'(bus.wr_gnt), 32'b010);
    chk("nc_rd_addr", 32'(bus.mem_rd_addr), 32'(BD));
    chk("nc_wr_data", bus.mem_wr_data, 32'hDEADBEEF);
    tick();
    idle();
    chk("nc_cnt", 32'(bus.conflict_cnt), 1);

    // read single bank 3 vs write double bank 1 (pair 1,3): conflict
    bus.rd_req = 3'b001; bus.rd_addr[0] = 16'(3 * BD);
    bus.wr_req = 3'b001; bus.wr_addr[0] = 16'(BD + 1); bus.wr_width = 3'b001;
    #1 chk("cf13_rd_gnt", 32'(bus.rd_gnt), 0);
    tick();
    // read double bank 0 (pair 0,2) vs write single bank 3: no conflict
    bus.rd_addr[0] = 16'd0; bus.rd_width = 3'b001;
    bus.wr_addr[0] = 16'(3 * BD + 4); bus.wr_width = 3'b000;
    #1;
    chk("cf13_cnt", 32'(bus.conflict_cnt), 2);
    chk("dw_gnts", {29'd0, bus.rd_gnt[0], bus.wr_gnt[0], bus.mem_rd_width}, 32'b111);
    tick();
    idle();

    // out-of-range write sets sticky flag; reset drops pending rvalid
    bus.wr_req = 3'b100; bus.wr_addr[2] = 16'(4 * BD);
    bus.rd_req = 3'b001; bus.rd_addr[0] = 16'(BD);
    #1;
    chk("oor_wr_gnt", 32'(bus.wr_gnt), 32'b100);
    chk("oor_rd_gnt", 32'(bus.rd_gnt), 32'b001);
    tick();
    idle();
    bus.mem_rd_data = 32'h5555AAAA;
    #1;
    chk("oor_flag", 32'(bus.oor_err), 1);
    chk("oor_rdata", bus.rd_rdata, 32'h5555AAAA);
    tick();
    chk("oor_hold", 32'(bus.oor_err), 1);
    bus.rd_req = 3'b001; bus.rd_addr[0] = 16'd9;
    tick();
    chk("pend_rvalid", 32'(bus.rd_rvalid), 32'b001);
    rst_n = 1'b0;
    bus.rd_req = 3'b111;
    #1;
    chk("mr_rvalid", 32'(bus.rd_rvalid), 0);
    chk("mr_rdata", bus.rd_rdata, 0);
    chk("mr_oor_cnt", {15'd0, bus.oor_err, bus.conflict_cnt}, 0);
    chk("mr_gnt", 32'(bus.rd_gnt), 0);
    tick();
    rst_n = 1'b1;
    #1 chk("mr_first_gnt", 32'(bus.rd_gnt), 32'b001);
    tick();
    idle();

    // saturation: same requester reads and writes bank 0 every cycle
    bus.rd_req = 3'b001; bus.rd_addr[0] = 16'd5;
    bus.wr_req = 3'b001; bus.wr_addr[0] = 16'd7;
    repeat (65534) tick();
    chk("sat_fffe", 32'(bus.conflict_cnt), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(bus.conflict_cnt), 32'hFFFF);
    repeat (70000 - 65535) tick();
    chk("sat_hold", 32'(bus.conflict_cnt), 32'hFFFF);
    chk("sat_rd_gnt", 32'(bus.rd_gnt), 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
